dff_bank_arbiter: RTL and testbench

- Round-robin arbiter and load sequencer for a shared WIDTH-bit D-flip-flop register bank.
- N requesters compete to write the bank. The block grants one requester at a time, loads that requester's data into the bank, then holds the value stable for a programmable number of cycles before re-arbitrating.
- Sits between producer logic and any consumer of the shared registered value q.

---
 rtl/dff_bank_arbiter_if.sv | 33 +++
 rtl/dff_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter_if
// Description : Request/data/grant bundle between producers and the shared
//               register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_bank_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                 en;
    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   wr_data;
    logic [WIDTH-1:0]     q;
    logic [N-1:0]         grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 busy;
    logic                 loaded;

    modport master (
        output en, req, wr_data,
        input  q, grant, grant_idx, busy, loaded
    );

    modport slave (
        input  en, req, wr_data,
        output q, grant, grant_idx, busy, loaded
    );
endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin arbiter that loads one requester's data into a
//               shared register bank, then holds it for HOLD_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int              N           = 4,
    parameter int              WIDTH       = 8,
    parameter int              HOLD_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    dff_bank_arbiter_if.slave   arb
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int CNT_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   q_q;
    logic [N-1:0]       grant_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               loaded_q;

    logic               win_found_d;
    logic [IDX_W-1:0]   win_idx_d;
    logic [IDX_W-1:0]   cand_d;
    logic [N-1:0]       win_onehot_d;
    logic [WIDTH-1:0]   slice_d;

    // Rotating search starting one past the most recently served requester.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand_d      = '0;
        for (int k = 1; k <= N; k++) begin
            cand_d = IDX_W'((int'(last_q) + k) % N);
            if (!win_found_d && arb.req[cand_d]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_d;
            end
        end
    end

    assign win_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx_d;

    always_comb begin
        slice_d = arb.wr_data[WIDTH-1:0];
        for (int i = 0; i < N; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                slice_d = arb.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            q_q         <= RESET_VALUE;
            grant_q     <= '0;
            grant_idx_q <= IDX_W'(N - 1);
            last_q      <= IDX_W'(N - 1);
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb.en && win_found_d) begin
                        grant_q     <= win_onehot_d;
                        grant_idx_q <= win_idx_d;
                        busy_q      <= 1'b1;
                        state_q     <= S_GRANT;
                    end else begin
                        grant_q     <= '0;
                    end
                end
                // The grant is committed: load regardless of req/en now.
                S_GRANT: begin
                    q_q      <= slice_d;
                    loaded_q <= 1'b1;
                    last_q   <= grant_idx_q;
                    grant_q  <= '0;
                    if (HOLD_CYCLES == 0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_HOLD;
                        cnt_q   <= CNT_W'(CNT_LOAD);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb.q         = q_q;
    assign arb.grant     = grant_q;
    assign arb.grant_idx = grant_idx_q;
    assign arb.busy      = busy_q;
    assign arb.loaded    = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Directed self-checking bench for dff_bank_arbiter
//               (HOLD_CYCLES=2 main instance, HOLD_CYCLES=0 second instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dff_bank_arbiter_if #(.N(4), .WIDTH(8)) ifa ();
    dff_bank_arbiter_if #(.N(4), .WIDTH(8)) ifb ();

    dff_bank_arbiter #(.N(4), .WIDTH(8), .HOLD_CYCLES(2), .RESET_VALUE(8'h00)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .arb (ifa.slave)
    );

    dff_bank_arbiter #(.N(4), .WIDTH(8), .HOLD_CYCLES(0), .RESET_VALUE(8'h00)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .arb (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_idx [5];
        logic [7:0] exp_q   [5];
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        n_cmp = 0;
        n_err = 0;

        rst = 1'b1;
        ifa.en = 1'b1; ifa.req = 4'b0000; ifa.wr_data = '0;
        ifb.en = 1'b1; ifb.req = 4'b0000; ifb.wr_data = '0;
        step();
        step();
        chk("rst_q",         32'(ifa.q),         32'h00);
        chk("rst_grant",     32'(ifa.grant),     32'h0);
        chk("rst_grant_idx", 32'(ifa.grant_idx), 32'd3);
        chk("rst_busy",      32'(ifa.busy),      32'd0);
        chk("rst_loaded",    32'(ifa.loaded),    32'd0);

        // Test 1: single request from requester 2
        rst = 1'b0;
        ifa.req = 4'b0100;
        ifa.wr_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        step();
        chk("t1_grant",     32'(ifa.grant),     32'b0100);
        chk("t1_grant_idx", 32'(ifa.grant_idx), 32'd2);
        chk("t1_busy_c1",   32'(ifa.busy),      32'd1);
        chk("t1_q_c1",      32'(ifa.q),         32'h00);
        ifa.req = 4'b0000;
        step();
        chk("t1_q_c2",      32'(ifa.q),         32'hA5);
        chk("t1_loaded",    32'(ifa.loaded),    32'd1);
        chk("t1_grant_c2",  32'(ifa.grant),     32'h0);
        chk("t1_busy_c2",   32'(ifa.busy),      32'd1);
        step();
        chk("t1_busy_c3",   32'(ifa.busy),      32'd1);
        step();
        chk("t1_busy_c4",   32'(ifa.busy),      32'd0);

        // Test 2: all requesting after a fresh reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ifa.req = 4'b1111;
        ifa.wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant",     32'(ifa.grant),     32'(4'b0001 << exp_idx[k]));
            chk("t2_grant_idx", 32'(ifa.grant_idx), 32'(exp_idx[k]));
            step();
            chk("t2_q",         32'(ifa.q),         32'(exp_q[k]));
            chk("t2_grant_off", 32'(ifa.grant),     32'h0);
            step();
            step();
        end

        // Test 3: serve idx 2, then req 0011 must wrap past idx 3 to idx 0, then 1
        ifa.req = 4'b0100;
        step();
        chk("t3_grant_2",   32'(ifa.grant_idx), 32'd2);
        ifa.req = 4'b0000;
        step();
        step();
        step();
        ifa.req = 4'b0011;
        step();
        chk("t3_grant_0",   32'(ifa.grant),     32'b0001);
        chk("t3_idx_0",     32'(ifa.grant_idx), 32'd0);
        step();
        chk("t3_q_0",       32'(ifa.q),         32'h11);
        step();
        step();
        step();
        chk("t3_grant_1",   32'(ifa.grant),     32'b0010);
        chk("t3_idx_1",     32'(ifa.grant_idx), 32'd1);
        step();
        chk("t3_q_1",       32'(ifa.q),         32'h22);
        ifa.req = 4'b0000;
        step();
        step();
        chk("t3_idle",      32'(ifa.busy),      32'd0);
        chk("t3_hold_idx",  32'(ifa.grant_idx), 32'd1);

        // Test 5: en gating, then en dropped during the grant cycle
        ifa.en = 1'b0;
        ifa.req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_no_grant", 32'(ifa.grant), 32'h0);
            chk("t5_no_busy",  32'(ifa.busy),  32'd0);
            chk("t5_q_held",   32'(ifa.q),     32'h22);
        end
        ifa.en = 1'b1;
        step();
        chk("t5_grant_3",   32'(ifa.grant),     32'b1000);
        ifa.en = 1'b0;
        ifa.req = 4'b0000;
        step();
        chk("t5_q_loaded",  32'(ifa.q),         32'h44);
        ifa.en = 1'b1;
        step();
        step();

        // Test 6: reset in the grant cycle aborts the load
        ifa.req = 4'b0001;
        ifa.wr_data = {8'h44, 8'h33, 8'h22, 8'hFF};
        step();
        chk("t6_grant_0",   32'(ifa.grant),     32'b0001);
        rst = 1'b1;
        step();
        chk("t6_q",         32'(ifa.q),         32'h00);
        chk("t6_grant",     32'(ifa.grant),     32'h0);
        chk("t6_busy",      32'(ifa.busy),      32'd0);
        chk("t6_loaded",    32'(ifa.loaded),    32'd0);
        chk("t6_grant_idx", 32'(ifa.grant_idx), 32'd3);
        rst = 1'b0;
        ifa.req = 4'b1111;
        step();
        chk("t6_first_idx", 32'(ifa.grant_idx), 32'd0);
        chk("t6_first_gnt", 32'(ifa.grant),     32'b0001);
        ifa.req = 4'b0000;
        step();
        chk("t6_q_ff",      32'(ifa.q),         32'hFF);

        // Test 4: HOLD_CYCLES=0 instance, continuous request from idx 0
        ifb.req = 4'b0001;
        ifb.wr_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t4_busy",  32'(ifb.busy),  32'(k % 2));
            chk("t4_grant", 32'(ifb.grant), (k % 2 == 1) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                chk("t4_q", 32'(ifb.q), 32'h5A);
            end
        end
        ifb.req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
